// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of a single-port memory
// with fixed read latency; routes read data back through an in-order tag pipeline.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [DATA_W/8-1:0] i_dm_sel,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_mem_ce,
    output logic                o_mem_we,
    output logic [DATA_W/8-1:0] o_mem_sel,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int CNT_W = 4;

    // Handshake: a requester holds req and its fields stable until gnt is seen;
    // gnt is combinational in the request cycle and the request is consumed on
    // the rising edge where gnt=1. The memory never back-pressures.

    logic [CNT_W-1:0]  starve_cnt;
    logic              starved;
    logic              if_win;
    logic              dm_win;
    logic              push_vld;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;  // 1 = fetch owns the read, 0 = data port

    always_comb begin
        starved  = (starve_cnt == CNT_W'(STARVE_MAX));
        if_win   = i_rst_n & i_if_req & (~i_dm_req | starved);
        dm_win   = i_rst_n & i_dm_req & ~if_win;
        push_vld = if_win | (dm_win & ~i_dm_we);
    end

    always_comb begin
        o_if_gnt    = if_win;
        o_dm_gnt    = dm_win;
        o_mem_ce    = if_win | dm_win;
        o_mem_we    = dm_win & i_dm_we;
        o_mem_sel   = '0;
        o_mem_addr  = i_dm_addr;
        o_mem_wdata = i_dm_wdata;
        if (if_win) begin
            o_mem_sel  = '1;
            o_mem_addr = i_if_addr;
        end else if (dm_win) begin
            o_mem_sel  = i_dm_sel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!i_if_req || if_win) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Writes enter the pipeline as invalid slots so read order is preserved.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
            tag_vld[0] <= push_vld;
            tag_own[0] <= if_win;
        end
    end

    always_comb begin
        o_if_rvalid = tag_vld[RD_LAT-1] & tag_own[RD_LAT-1];
        o_dm_rvalid = tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
        o_if_rdata  = i_mem_rdata;
        o_dm_rdata  = i_mem_rdata;
    end

endmodule
